// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
//   Shared definitions for the timer path: the tick-controller FSM state type
//   and the terminal value of the downstream 4-bit counter.
// -----------------------------------------------------------------------------
package timer_pkg;

    // FSM state encoding, also exported on state_o.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } tmr_state_t;

    // Value at which the downstream counter asserts tc.
    localparam logic [3:0] CNT_MAX = 4'd15;

endpackage

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
//   Loadable down-counter that divides clk into a tick every val+1 enabled
//   cycles. On reaching zero while enabled it reloads val and flags tick, so
//   a new val only takes effect at a reload and never cuts a period short.
//
// Ports
//   clk    in   1      system clock
//   clr_n  in   1      asynchronous active-low reset
//   load   in   1      load val immediately (wins over en)
//   en     in   1      count enable; low freezes the current value
//   val    in   PSC_W  reload value
//   tick   out  1      combinational: this enabled cycle is the last of a period
//   value  out  PSC_W  current count
// -----------------------------------------------------------------------------
module timer_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic             en,
    input  logic [PSC_W-1:0] val,
    output logic             tick,
    output logic [PSC_W-1:0] value
);

    logic [PSC_W-1:0] cnt_q;
    logic             at_zero;

    assign at_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= val;
        end else if (en) begin
            if (at_zero) begin
                cnt_q <= val;
            end else begin
                cnt_q <= cnt_q - PSC_W'(1);
            end
        end
    end

    // A load restarts the period, so it suppresses any tick in that cycle.
    assign tick  = en & ~load & at_zero;
    assign value = cnt_q;

endmodule

// File: rtl/timer_tick_ctrl.sv
// -----------------------------------------------------------------------------
// timer_tick_ctrl
//   Control stage in front of the 4-bit synchronous timer counter. Divides clk
//   by psc_val+1 into counter enable pulses, runs a start/pause/stop FSM in
//   one-shot or periodic mode, and raises a level interrupt on every counter
//   wrap, counting wraps that arrive while the interrupt is still pending.
//
// Ports
//   clk       in   1       system clock
//   clr_n     in   1       asynchronous active-low reset
//   start     in   1       pulse: begin / restart timing
//   stop      in   1       pulse: abort to IDLE (wins over start)
//   pause     in   1       level: freeze prescaler and counter while running
//   oneshot   in   1       1 = stop after first wrap; latched on start
//   psc_val   in   PSC_W   prescale reload value
//   cnt_tc    in   1       counter terminal count
//   cnt_en    out  1       counter enable, one-cycle tick pulse
//   cnt_clr   out  1       counter synchronous clear, one-cycle pulse
//   cnt_prs   out  1       counter preset, unused (tied 0)
//   irq       out  1       level interrupt, set on wrap, cleared by irq_ack
//   irq_ack   in   1       pulse: acknowledge irq
//   busy      out  1       high in RUN or HOLD
//   state_o   out  2       FSM state (IDLE=0 RUN=1 HOLD=2 DONE=3)
//   miss_cnt  out  MISS_W  saturating count of wraps while irq pending
// -----------------------------------------------------------------------------
module timer_tick_ctrl
    import timer_pkg::*;
#(
    parameter int PSC_W  = 8,
    parameter int MISS_W = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              oneshot,
    input  logic [PSC_W-1:0]  psc_val,
    input  logic              cnt_tc,
    output logic              cnt_en,
    output logic              cnt_clr,
    output logic              cnt_prs,
    output logic              irq,
    input  logic              irq_ack,
    output logic              busy,
    output logic [1:0]        state_o,
    output logic [MISS_W-1:0] miss_cnt
);

    tmr_state_t       state_q;
    tmr_state_t       state_d;
    logic             oneshot_q;
    logic             oneshot_d;
    logic             cnt_en_d;
    logic             cnt_clr_d;
    logic             psc_load;
    logic             psc_en;
    logic             psc_tick;
    logic [PSC_W-1:0] psc_value_unused;
    logic             wrap;

    function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
        return (&v) ? v : v + MISS_W'(1);
    endfunction

    timer_prescaler #(
        .PSC_W (PSC_W)
    ) u_psc (
        .clk   (clk),
        .clr_n (clr_n),
        .load  (psc_load),
        .en    (psc_en),
        .val   (psc_val),
        .tick  (psc_tick),
        .value (psc_value_unused)
    );

    // The counter rolls 15->0 on the edge where it is enabled at terminal count.
    assign wrap = cnt_en & cnt_tc;

    // Next-state and next-output decode. Priority: stop > start > wrap > pause.
    always_comb begin
        state_d   = state_q;
        oneshot_d = oneshot_q;
        psc_load  = 1'b0;
        psc_en    = 1'b0;
        cnt_en_d  = 1'b0;
        cnt_clr_d = 1'b0;

        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d   = RUN;
            oneshot_d = oneshot;
            psc_load  = 1'b1;
            cnt_clr_d = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (wrap && oneshot_q) begin
                        state_d = DONE;
                    end else begin
                        // pause acts on the very edge it is sampled, so the
                        // period stretches by exactly the cycles pause is high.
                        psc_en   = ~pause;
                        cnt_en_d = psc_tick;
                        if (pause) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    psc_en   = ~pause;
                    cnt_en_d = psc_tick;
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            oneshot_q <= 1'b0;
            cnt_en    <= 1'b0;
            cnt_clr   <= 1'b0;
        end else begin
            state_q   <= state_d;
            oneshot_q <= oneshot_d;
            cnt_en    <= cnt_en_d;
            cnt_clr   <= cnt_clr_d;
        end
    end

    // A wrap always wins over an ack landing in the same cycle; only a wrap
    // seen while irq is pending and not being acked counts as missed.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            irq      <= 1'b0;
            miss_cnt <= '0;
        end else if (wrap) begin
            irq <= 1'b1;
            if (irq && !irq_ack) begin
                miss_cnt <= sat_inc(miss_cnt);
            end
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end

    assign cnt_prs = 1'b0;
    assign busy    = (state_q == RUN) || (state_q == HOLD);
    assign state_o = state_q;

endmodule

// File: tb/tb_timer_tick_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_tick_ctrl
//   Directed bench for timer_tick_ctrl with a behavioural model of the 4-bit
//   counter it drives. Cycle 0 is the cycle in which cnt_clr is high after a
//   start; inputs are driven 1 time unit after a rising edge and outputs are
//   read at the same point.
// -----------------------------------------------------------------------------
module tb_timer_tick_ctrl;
    import timer_pkg::*;

    localparam int PSC_W  = 8;
    localparam int MISS_W = 4;

    logic              clk;
    logic              clr_n;
    logic              start;
    logic              stop;
    logic              pause;
    logic              oneshot;
    logic [PSC_W-1:0]  psc_val;
    logic              cnt_tc;
    logic              cnt_en;
    logic              cnt_clr;
    logic              cnt_prs;
    logic              irq;
    logic              irq_ack;
    logic              busy;
    logic [1:0]        state_o;
    logic [MISS_W-1:0] miss_cnt;

    logic [3:0] ctr;
    int n_checks = 0;
    int n_fail   = 0;

    timer_tick_ctrl #(
        .PSC_W  (PSC_W),
        .MISS_W (MISS_W)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .oneshot  (oneshot),
        .psc_val  (psc_val),
        .cnt_tc   (cnt_tc),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .cnt_prs  (cnt_prs),
        .irq      (irq),
        .irq_ack  (irq_ack),
        .busy     (busy),
        .state_o  (state_o),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 4-bit counter.
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n)       ctr <= 4'd0;
        else if (cnt_clr) ctr <= 4'd0;
        else if (cnt_en)  ctr <= ctr + 4'd1;
    end
    assign cnt_tc = (ctr == CNT_MAX);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [PSC_W-1:0] pv, input logic os);
        psc_val = pv;
        oneshot = os;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        clr_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        pause   = 1'b0;
        oneshot = 1'b0;
        psc_val = '0;
        irq_ack = 1'b0;

        // Reset state
        repeat (2) step();
        check("rst state", state_o, 0);
        check("rst en", cnt_en, 0);
        check("rst clr", cnt_clr, 0);
        check("rst prs", cnt_prs, 0);
        check("rst irq", irq, 0);
        check("rst miss", miss_cnt, 0);
        check("rst busy", busy, 0);
        clr_n = 1'b1;
        step();

        // pause has no effect in IDLE
        pause = 1'b1;
        step();
        check("idle pause state", state_o, 0);
        pause = 1'b0;

        // Periodic, psc_val=3: tick every 4th cycle, wraps at 64/128/192/256.
        // Ack coincides with the wrap at 256, then a plain ack at 257.
        do_start(8'd3, 1'b0);
        check("A clr c0", cnt_clr, 1);
        check("A en c0", cnt_en, 0);
        check("A state c0", state_o, 1);
        check("A busy c0", busy, 1);
        for (int c = 1; c <= 259; c++) begin
            irq_ack = (c == 257) || (c == 258);
            step();
            check($sformatf("A en c%0d", c), cnt_en, (c % 4) == 0);
            check($sformatf("A irq c%0d", c), irq, (c >= 65) && (c < 258));
            check($sformatf("A miss c%0d", c), miss_cnt, (c >= 193) ? 2 : ((c >= 129) ? 1 : 0));
        end
        irq_ack = 1'b0;
        check("A clr after", cnt_clr, 0);
        // stop on the edge that would otherwise launch the tick at cycle 260
        do_stop();
        check("A stop state", state_o, 0);
        check("A stop en", cnt_en, 0);
        check("A stop busy", busy, 0);
        check("A stop miss", miss_cnt, 2);

        // One-shot, psc_val=0: tick every cycle, wrap at tick 16 -> DONE.
        // oneshot drops right after start to show it is latched.
        do_start(8'd0, 1'b1);
        oneshot = 1'b0;
        check("B clr c0", cnt_clr, 1);
        check("B en c0", cnt_en, 0);
        for (int c = 1; c <= 16; c++) begin
            step();
            check($sformatf("B en c%0d", c), cnt_en, 1);
            check($sformatf("B state c%0d", c), state_o, 1);
        end
        step();
        check("B done state", state_o, 3);
        check("B done busy", busy, 0);
        check("B done en", cnt_en, 0);
        check("B done irq", irq, 1);
        check("B done miss", miss_cnt, 2);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("B ack irq", irq, 0);
        check("B hold en", cnt_en, 0);
        check("B hold state", state_o, 3);
        do_stop();
        check("B stop state", state_o, 0);

        // psc_val=7, pause sampled on 10 edges starting after the 3rd tick.
        do_start(8'd7, 1'b0);
        for (int c = 1; c <= 45; c++) begin
            pause = (c >= 26) && (c <= 35);
            step();
            check($sformatf("C en c%0d", c), cnt_en,
                  (c == 8) || (c == 16) || (c == 24) || (c == 42));
            check($sformatf("C state c%0d", c), state_o, ((c >= 26) && (c <= 35)) ? 2 : 1);
        end
        pause = 1'b0;
        do_stop();
        check("C stop state", state_o, 0);

        // start & stop together while running: stop wins, no clear pulse.
        do_start(8'd3, 1'b0);
        repeat (3) step();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("D state", state_o, 0);
        check("D clr", cnt_clr, 0);
        check("D en", cnt_en, 0);
        check("D busy", busy, 0);

        // psc_val 3->9 mid-period: ticks at 4, 8, then 18. Then restart in RUN.
        do_start(8'd3, 1'b0);
        for (int c = 1; c <= 18; c++) begin
            if (c == 6) psc_val = 8'd9;
            step();
            check($sformatf("E en c%0d", c), cnt_en, (c == 4) || (c == 8) || (c == 18));
        end
        do_start(8'd9, 1'b0);
        check("E restart clr", cnt_clr, 1);
        check("E restart state", state_o, 1);
        for (int c = 1; c <= 10; c++) begin
            step();
            check($sformatf("E2 en c%0d", c), cnt_en, c == 10);
        end
        do_stop();

        // Asynchronous reset between edges while running with cnt_en high.
        do_start(8'd0, 1'b0);
        repeat (3) step();
        check("F pre en", cnt_en, 1);
        #2;
        clr_n = 1'b0;
        #1;
        check("F rst state", state_o, 0);
        check("F rst en", cnt_en, 0);
        check("F rst clr", cnt_clr, 0);
        check("F rst irq", irq, 0);
        check("F rst miss", miss_cnt, 0);
        check("F rst busy", busy, 0);
        step();
        clr_n = 1'b1;
        step();
        check("F idle state", state_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
